// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and per-entry scrub init value for the register file.
// Build option: define REGFILE_SEED_INIT_EN to seed entry i with i+1 (entry 0 stays 0).
package regfile_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;

`ifdef REGFILE_SEED_INIT_EN
  localparam bit RF_SEED_EN = 1'b1;
`else
  localparam bit RF_SEED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    RF_RESET = 2'd0,
    RF_CLEAR = 2'd1,
    RF_READY = 2'd2
  } rf_state_e;

  // Seeded build preloads 2..DEPTH, the layout the bubble-sort test programs expect.
  function automatic logic [RF_DATA_W-1:0] rf_init_value(input int unsigned idx);
    if (RF_SEED_EN && idx != 0) begin
      return RF_DATA_W'(idx) + RF_DATA_W'(1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Post-reset scrub sequencer: walks every entry once, then holds ready until the next reset.
// Build option REGFILE_SEED_INIT_EN only changes the data written, not this timing.
module regfile_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              ready,
  output logic              scrub_done
);

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

  rf_state_e       state;
  logic [ADDR_W:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RF_RESET;
      count      <= '0;
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= 1'b0;
      case (state)
        RF_RESET: state <= RF_CLEAR;
        RF_CLEAR: begin
          count <= count + (ADDR_W + 1)'(1);
          if (count == LAST) begin
            state      <= RF_READY;
            scrub_done <= 1'b1;
          end
        end
        RF_READY: state <= RF_READY;
        default:  state <= RF_RESET;
      endcase
    end
  end

  assign scrub_we   = (state == RF_CLEAR);
  assign scrub_addr = count[ADDR_W-1:0];
  assign ready      = (state == RF_READY);

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: one write port, NUM_RD combinational read ports, x0 reads zero,
// same-cycle write bypass, post-reset scrub. Build option: REGFILE_SEED_INIT_EN (seeded scrub).
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready,
  output logic                     scrub_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;
  logic              ext_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem [DEPTH];

  regfile_scrub_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_scrub (
    .clk        (clk),
    .reset      (reset),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr),
    .ready      (ready),
    .scrub_done (scrub_done)
  );

  assign ext_we = ready && we && (waddr != '0);

  // NOTE: every signal gets a default first in always_comb so no path infers a latch.
  always_comb begin
    wr_en   = scrub_we;
    wr_addr = scrub_addr;
    wr_data = DATA_W'(rf_init_value(32'(scrub_addr)));
    if (!scrub_we) begin
      wr_en   = ext_we;
      wr_addr = waddr;
      wr_data = wdata;
    end
  end

  // NOTE: the array has no reset branch; the scrub FSM initialises it, keeping it RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] lane;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      lane = '0;
      if (ready && ra != '0) begin
        lane = (ext_we && waddr == ra) ? wdata : mem[ra];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = lane;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized self-checking bench for regfile_multiport against an array-based reference model.
module tb_regfile_multiport;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 2 ** AW;

  logic             clk = 1'b0;
  logic             reset;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             ready;
  logic             scrub_done;

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .ready      (ready),
    .scrub_done (scrub_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: contents array plus count of edges since reset was released.
  logic [63:0] ref_mem [DEPTH];
  int          ref_edges = 0;
  bit          known     = 1'b0;

  function automatic logic [63:0] init_val(input int i);
`ifdef REGFILE_SEED_INIT_EN
    return (i == 0) ? 64'd0 : 64'(i + 1);
`else
    return (i < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_read(input int a, input bit w, input int wa,
                                           input logic [63:0] wd);
    if (ref_edges < DEPTH + 1 || a == 0) return 64'd0;
    if (w && wa == a) return wd;
    return ref_mem[a];
  endfunction

  task automatic cycle(input bit r, input bit w, input logic [AW-1:0] wa,
                       input logic [63:0] wd, input logic [NR*AW-1:0] ra);
    reset = r; we = w; waddr = wa; wdata = wd; raddr = ra;
    @(negedge clk);
    if (known) begin
      check("ready", 64'(ready), 64'(ref_edges >= DEPTH + 1));
      check("scrub_done", 64'(scrub_done), 64'(ref_edges == DEPTH + 1));
      for (int k = 0; k < NR; k++) begin
        check($sformatf("rdata%0d[a=%0d]", k, ra[k*AW +: AW]), rdata[k*DW +: DW],
              exp_read(int'(ra[k*AW +: AW]), w, int'(wa), wd));
      end
    end
    @(posedge clk);
    if (ref_edges >= DEPTH + 1 && w && wa != 0) ref_mem[wa] = wd;
    if (!r) begin
      ref_edges = 0;
      known     = 1'b1;
    end else if (ref_edges < DEPTH + 2) begin
      ref_edges++;
      if (ref_edges == DEPTH + 1)
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    end
    #1;
  endtask

  function automatic logic [NR*AW-1:0] pick_ra(input logic [AW-1:0] wa);
    logic [NR*AW-1:0] v;
    for (int k = 0; k < NR; k++)
      v[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
    return v;
  endfunction

  task automatic rand_cycles(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] wa;
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
      cycle(r, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, pick_ra(wa));
    end
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a += NR)
      cycle(1'b1, 1'b0, '0, '0, {AW'(a + 3), AW'(a + 2), AW'(a + 1), AW'(a)});
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;

    repeat (5) cycle(1'b0, 1'b0, '0, '0, '0);

    // Scrub window with random (ignored) writes; directed write to entry 20 mid-scrub.
    for (int i = 0; i < 40; i++) begin
      if (i == 10) cycle(1'b1, 1'b1, 5'd20, 64'hAA, {NR{5'd20}});
      else rand_cycles(1, 1'b1);
    end
    sweep();

    cycle(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, {5'd0, 5'd0, 5'd6, 5'd5});
    cycle(1'b1, 1'b0, '0, '0, {5'd0, 5'd0, 5'd6, 5'd5});

    cycle(1'b1, 1'b1, 5'd0, 64'hFFFF, {NR{5'd0}});
    cycle(1'b1, 1'b0, '0, '0, {NR{5'd0}});

    cycle(1'b1, 1'b1, 5'd12, 64'h1234, {NR{5'd12}});
    cycle(1'b1, 1'b0, '0, '0, {NR{5'd12}});

    rand_cycles(300, 1'b1);
    sweep();

    // Reset mid-scrub: one cycle low, release, 15 scrub cycles, one more low cycle.
    cycle(1'b0, 1'b0, '0, '0, '0);
    rand_cycles(15, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, '0);
    rand_cycles(40, 1'b1);
    sweep();
    rand_cycles(100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the processor's integer register file: DEPTH × DATA_W storage, NUM_RD combinational read ports, one write port, x0 hard-wired to zero, and write-to-read bypass for same-cycle forwarding in the pipeline. After reset, a scrub state machine initialises every entry one per cycle and raises `ready`. The pipeline must hold decode/writeback until `ready` is high. The block sits between the decode stage (reads) and the writeback stage (write).

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset: sampled on `clk` rising edge, low = in reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rdata  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- ready  output  1  high once scrub is complete; the array is usable
- scrub_done  output  1  single-cycle pulse on the cycle `ready` first rises

## Operation
- FSM states: RF_RESET, RF_CLEAR, RF_READY.
- RF_RESET: entered whenever `reset` is sampled low, from any state. While in this state: scrub counter = 0, `ready` = 0, `scrub_done` = 0.
- RF_RESET → RF_CLEAR on the first edge with `reset` high.
- RF_CLEAR: each cycle, writes init value to entry[counter], then counter += 1.
- RF_CLEAR → RF_READY on the edge that writes entry DEPTH-1. `scrub_done` pulses for exactly that cycle.
- RF_READY: terminal state until the next reset.
- Init value: 0 for all entries (see Configuration for the seeded variant).
- Writes: in RF_READY, `we`=1 with `waddr`≠0 writes `wdata` at the edge. Writes to address 0 are discarded. `we` is ignored in RF_RESET and RF_CLEAR.
- Reads are combinational, zero latency, and independent per port:
  - not `ready`: returns 0;
  - `raddr`=0: returns 0;
  - bypass hit (`we`=1, `waddr`==`raddr`≠0, `ready`): returns `wdata`;
  - otherwise: returns entry[`raddr`].
- Any number of ports may read the same address in one cycle; all see identical data.
- Reset mid-scrub: returns to RF_RESET and the counter restarts from 0. Partially scrubbed contents are overwritten by the next full scrub.
- The counter is ADDR_W+1 bits wide so the terminal compare does not wrap.

## Timing
- Scrub latency: `ready` rises DEPTH+1 edges after the first edge with `reset` high (one edge RF_RESET→RF_CLEAR, then DEPTH writes). With ADDR_W=5, this is 33 edges.
- Write-to-read: same-cycle via bypass; from storage on the following cycle.
- Reset values: `ready`=0, `scrub_done`=0, all `rdata` lanes=0.
- No outputs depend on `reset` combinationally. They are derived from registered state only, plus the combinational read path.

## Configuration
- Macro `REGFILE_SEED_INIT_EN`.
  - Defined: the scrub writes value i+1 into entry i for i≥1 (entry 0 stays 0). This gives DATA_W-wide values 2, 3, …, DEPTH, matching the preloaded state the existing bubble-sort test programs expect.
  - Undefined: the scrub writes 0 to every entry.
- Scrub duration and all timing are identical in both builds.

## Structure
- Package `regfile_pkg`:
  - default DATA_W/ADDR_W constants;
  - state enum {RF_RESET, RF_CLEAR, RF_READY};
  - function `rf_init_value(idx)` returning the per-entry init value, guarded by `REGFILE_SEED_INIT_EN`.
- Sub-module `regfile_scrub_ctrl`: FSM plus counter. Outputs scrub write-enable, scrub address, `ready` and `scrub_done`.
- Top level: storage array, write mux (scrub vs. external), and a generate loop over NUM_RD read/bypass lanes.

## Test plan
- Reset held low 5 cycles, then released → `ready`=0 for 32 edges, `scrub_done` pulse and `ready`=1 at edge 33. All entries read 0; entry 7 reads 8 with `REGFILE_SEED_INIT_EN` defined.
- Write 0xDEAD_BEEF to entry 5 with port 0 reading 5 in the same cycle → port 0 returns 0xDEAD_BEEF that cycle (bypass) and the next cycle (storage). Port 1 reading 6 is unaffected.
- `we`=1, `waddr`=0, `wdata`=0xFFFF → raddr 0 returns 0 in that cycle and afterwards. No bypass.
- NUM_RD=4, all ports read entry 12 after writing 0x1234 → all four lanes return 0x1234.
- Write attempted during RF_CLEAR (cycle 10 of scrub) to entry 20 with 0xAA → ignored. Entry 20 holds its init value after `ready`.
- Reset asserted at scrub cycle 15 for 1 cycle → `ready` stays 0 and rises 33 edges after release. No `scrub_done` pulse before then.
